// File: rtl/expr_pkg.sv
// Shared constants and types for the arithmetic expression stream evaluator
// and its character classifier.
package expr_pkg;

  localparam logic [7:0] CH_0   = 8'd48;
  localparam logic [7:0] CH_9   = 8'd57;
  localparam logic [7:0] CH_ADD = 8'd43;
  localparam logic [7:0] CH_MUL = 8'd42;
  localparam logic [7:0] CH_EQ  = 8'd61;

  typedef enum logic [1:0] {
    EXP_DIGIT = 2'd0,
    EXP_OP    = 2'd1,
    ERR       = 2'd2,
    RESULT    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CL_DIGIT = 3'd0,
    CL_ADD   = 3'd1,
    CL_MUL   = 3'd2,
    CL_EQ    = 3'd3,
    CL_OTHER = 3'd4
  } char_class_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: maps a character to its class and, for
// digits, its numeric value.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls,
  output logic [3:0]  dval
);

  always_comb begin
    cls  = CL_OTHER;
    dval = 4'd0;
    if (ch >= CH_0 && ch <= CH_9) begin
      cls  = CL_DIGIT;
      dval = 4'(ch - CH_0);
    end else if (ch == CH_ADD) begin
      cls = CL_ADD;
    end else if (ch == CH_MUL) begin
      cls = CL_MUL;
    end else if (ch == CH_EQ) begin
      cls = CL_EQ;
    end
  end

endmodule

// File: rtl/expr_stream_eval.sv
// Streaming evaluator for digit (op digit)* expressions with '*' over '+'
// precedence; '=' closes an expression and strobes the result.
//
// state     | meaning
// EXP_DIGIT | waiting for a digit (expression start or after an operator)
// EXP_OP    | waiting for '+', '*' or '='
// ERR       | syntax error seen, absorbing characters until '='
// RESULT    | one-cycle result strobe, input stalled
module expr_stream_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  output logic         in_ready,
  output logic         res_valid,
  output logic [W-1:0] res_value,
  output logic         res_error,
  output logic         busy
);

  state_t      state_q, state_n;
  logic [W-1:0] sum_q, sum_n, prod_q, prod_n;
  logic [W-1:0] res_value_n;
  logic         mul_pend_q, mul_pend_n;
  logic         res_error_n;
  char_class_t  cls;
  logic [3:0]   dval;
  logic [W-1:0] dig_w;
  logic         xfer;

  expr_char_class u_class (
    .ch   (in_char),
    .cls  (cls),
    .dval (dval)
  );

  assign dig_w    = W'(dval);
  assign in_ready = (state_q != RESULT) && !clr;
  assign xfer     = in_valid && in_ready;
  // RESULT is a pure strobe cycle; the accumulators are cleared on its exit.
  assign busy     = (state_q != RESULT) &&
                    ((state_q != EXP_DIGIT) || (|sum_q) || (|prod_q) || mul_pend_q);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= EXP_DIGIT;
      sum_q      <= '0;
      prod_q     <= '0;
      mul_pend_q <= 1'b0;
      res_valid  <= 1'b0;
      res_value  <= '0;
      res_error  <= 1'b0;
    end else begin
      state_q    <= state_n;
      sum_q      <= sum_n;
      prod_q     <= prod_n;
      mul_pend_q <= mul_pend_n;
      res_valid  <= (state_n == RESULT);
      res_value  <= res_value_n;
      res_error  <= res_error_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    sum_n       = sum_q;
    prod_n      = prod_q;
    mul_pend_n  = mul_pend_q;
    res_value_n = res_value;
    res_error_n = res_error;
    case (state_q)
      EXP_DIGIT: begin
        if (xfer) begin
          case (cls)
            CL_DIGIT: begin
              prod_n     = mul_pend_q ? W'(prod_q * dig_w) : dig_w;
              mul_pend_n = 1'b0;
              state_n    = EXP_OP;
            end
            CL_EQ: begin
              res_value_n = '0;
              res_error_n = 1'b1;
              state_n     = RESULT;
            end
            default: state_n = ERR;
          endcase
        end
      end
      EXP_OP: begin
        if (xfer) begin
          case (cls)
            CL_ADD: begin
              sum_n   = sum_q + prod_q;
              state_n = EXP_DIGIT;
            end
            CL_MUL: begin
              mul_pend_n = 1'b1;
              state_n    = EXP_DIGIT;
            end
            CL_EQ: begin
              res_value_n = sum_q + prod_q;
              res_error_n = 1'b0;
              state_n     = RESULT;
            end
            default: state_n = ERR;
          endcase
        end
      end
      ERR: begin
        if (xfer && cls == CL_EQ) begin
          res_value_n = '0;
          res_error_n = 1'b1;
          state_n     = RESULT;
        end
      end
      RESULT: begin
        sum_n      = '0;
        prod_n     = '0;
        mul_pend_n = 1'b0;
        state_n    = EXP_DIGIT;
      end
      default: state_n = EXP_DIGIT;
    endcase
  end

endmodule

// File: tb/tb_expr_stream_eval.sv
// Scoreboard bench for expr_stream_eval: a string-level reference evaluator
// predicts each result; a monitor checks every strobe.
module tb_expr_stream_eval;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        res_valid;
  logic [15:0] res_value;
  logic        res_error;
  logic        busy;

  expr_stream_eval #(.W(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_value (res_value),
    .res_error (res_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] expr_buf[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit is_digit(input logic [7:0] c);
    return (c >= 8'd48 && c <= 8'd57);
  endfunction

  // Reference: validate the whole text against digit (op digit)*, then
  // evaluate as a sum of products of digits, all modulo 2^16.
  function automatic void model_eval(output logic [15:0] v, output logic e);
    int n = expr_buf.size();
    bit ok = (n % 2 == 1);
    int sum, term;
    for (int i = 0; i < n && ok; i++) begin
      if (i % 2 == 0) ok = is_digit(expr_buf[i]);
      else            ok = (expr_buf[i] == 8'd43 || expr_buf[i] == 8'd42);
    end
    if (!ok) begin
      v = 16'd0;
      e = 1'b1;
      return;
    end
    sum  = 0;
    term = int'(expr_buf[0]) - 48;
    for (int i = 1; i < n; i += 2) begin
      if (expr_buf[i] == 8'd42) begin
        term = (term * (int'(expr_buf[i+1]) - 48)) & 32'hFFFF;
      end else begin
        sum  = (sum + term) & 32'hFFFF;
        term = int'(expr_buf[i+1]) - 48;
      end
    end
    v = 16'((sum + term) & 32'hFFFF);
    e = 1'b0;
  endfunction

  task automatic model_accept(input logic [7:0] c, input int c0);
    exp_t x;
    if (c == 8'd61) begin
      model_eval(x.val, x.err);
      x.cyc = c0 + 1;
      sbq.push_back(x);
      expr_buf.delete();
    end else begin
      expr_buf.push_back(c);
    end
  endtask

  task automatic send_char(input logic [7:0] c, input int gap);
    int waited = 0;
    int c0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    c0 = cyc;
    @(posedge clk);
    model_accept(c, c0);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) send_char(q[i], int'($urandom_range(0, maxgap)));
  endtask

  task automatic do_clr(input bit with_eq);
    @(negedge clk);
    in_valid = with_eq;
    in_char  = 8'd61;
    clr      = 1'b1;
    #1 check("ready_during_clr", in_ready, 0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    expr_buf.delete();
    @(negedge clk);
    #3;
    check("no_strobe_after_clr", res_valid, 0);
    check("busy_after_clr", busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (res_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("res_value", res_value, e.val);
        check("res_error", res_error, e.err);
        check("strobe_cycle", cyc, e.cyc);
        check("ready_in_result", in_ready, 0);
        check("busy_in_result", busy, 0);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      check("missed_strobe", 0, 1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    clr      = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    #3;
    check("reset_res_valid", res_valid, 0);
    check("reset_res_value", res_value, 0);
    check("reset_res_error", res_error, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);

    send_str("0*1+2=", 0);
    send_str("3+4*5=", 0);
    send_str("9*9*9=", 0);
    send_str("1++2=", 0);
    send_str("7*=", 0);
    send_str("=", 0);
    send_str("a", 0);
    send_str("5=", 0);
    send_str("6=", 0);

    send_str("4*5", 0);
    @(negedge clk);
    #3 check("busy_mid_expr", busy, 1);
    do_clr(1'b0);
    send_str("2*3=", 0);
    send_str("8+1", 1);
    do_clr(1'b1);
    send_str("1+1=", 0);

    send_str("9*9*9*9*9*9=", 0);
    send_str("9*9*9*9*9*9=", 3);
    send_str("0*1+2=", 3);
    send_str("3+4*5=", 2);

    for (int k = 0; k < 150; k++) begin
      int n = int'($urandom_range(1, 7));
      q.delete();
      for (int i = 0; i < 2 * n - 1; i++) begin
        if (i % 2 == 0) q.push_back(8'(48 + $urandom_range(0, 9)));
        else            q.push_back(($urandom_range(0, 1) == 1) ? 8'd42 : 8'd43);
      end
      if ($urandom_range(0, 7) == 0) begin
        int p = int'($urandom_range(0, q.size() - 1));
        logic [7:0] bad = 8'($urandom_range(32, 126));
        if (bad == 8'd61) bad = 8'd32;
        q[p] = bad;
      end
      if ($urandom_range(0, 19) == 0) begin
        send_seq(q, 2);
        do_clr(1'b0);
      end else begin
        q.push_back(8'd61);
        send_seq(q, ($urandom_range(0, 1) == 1) ? 2 : 0);
      end
    end

    repeat (5) @(negedge clk);
    #3 check("queue_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
